// File: rtl/npu_dma_rd_stream_if.sv
// Control, Avalon-MM burst-read and output stream bundle for the DMA read engine.
// master = engine side, slave = memory/sequencer side.
interface npu_dma_rd_stream_if #(
    parameter int AXI_WIDTH = 64,
    parameter int ADDR_W    = 32,
    parameter int BURST_W   = 4
);
    logic                 start;
    logic [ADDR_W-1:0]    base_addr;
    logic [31:0]          total_beats;
    logic                 busy;
    logic                 done;
    logic [ADDR_W-1:0]    avm_address;
    logic                 avm_read;
    logic [BURST_W-1:0]   avm_burstcount;
    logic                 avm_waitrequest;
    logic [AXI_WIDTH-1:0] avm_readdata;
    logic                 avm_readdatavalid;
    logic [AXI_WIDTH-1:0] dma_data_out;
    logic                 dma_data_out_valid;
    logic                 dma_data_out_ready;

    modport master (
        input  start, base_addr, total_beats,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid,
        input  dma_data_out_ready,
        output busy, done,
        output avm_address, avm_read, avm_burstcount,
        output dma_data_out, dma_data_out_valid
    );

    modport slave (
        output start, base_addr, total_beats,
        output avm_waitrequest, avm_readdata, avm_readdatavalid,
        output dma_data_out_ready,
        input  busy, done,
        input  avm_address, avm_read, avm_burstcount,
        input  dma_data_out, dma_data_out_valid
    );
endinterface

// File: rtl/npu_dma_rd_stream.sv
// Burst-read engine: fetches total_beats words over Avalon-MM and streams them
// in order through a credit-guarded FWFT FIFO.
module npu_dma_rd_stream #(
    parameter int AXI_WIDTH  = 64,
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4,
    parameter int MAX_BURST  = 8,
    parameter int BURST_W    = 4
) (
    input logic clk,
    input logic rst,
    npu_dma_rd_stream_if.master io_bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_FINISH
    } state_t;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(AXI_WIDTH / 8);

    state_t r_state;
    state_t w_next;
    logic   w_busy;

    logic [ADDR_W-1:0]    r_addr_q;
    logic [31:0]          r_issue_rem;
    logic [31:0]          r_send_rem;
    logic [FIFO_AW:0]     r_fifo_cnt;
    logic [FIFO_AW:0]     r_outst;
    logic [FIFO_AW-1:0]   r_wptr;
    logic [FIFO_AW-1:0]   r_rptr;
    logic [AXI_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic                 r_avm_read;
    logic [ADDR_W-1:0]    r_avm_address;
    logic [BURST_W-1:0]   r_avm_bc;
    logic                 r_done;

    logic [31:0]        w_src_rem;
    logic [BURST_W-1:0] w_len;
    logic [FIFO_AW+1:0] w_need;
    logic               w_credit;
    logic               w_start;
    logic               w_issue;
    logic               w_accept;
    logic               w_rd;
    logic               w_full;
    logic               w_wr;
    logic               w_pop;
    logic [31:0]        w_issue_left;

    // The first burst leaves straight from IDLE so avm_read rises right after start.
    always_comb begin
        w_src_rem    = (r_state == S_IDLE) ? io_bus.total_beats : r_issue_rem;
        w_len        = (w_src_rem >= 32'(MAX_BURST)) ? BURST_W'(MAX_BURST)
                                                    : w_src_rem[BURST_W-1:0];
        w_need       = (FIFO_AW+2)'(r_fifo_cnt) + (FIFO_AW+2)'(r_outst)
                     + (FIFO_AW+2)'(w_len);
        w_credit     = w_need <= (FIFO_AW+2)'(FIFO_DEPTH);
        w_start      = (r_state == S_IDLE) && io_bus.start;
        w_accept     = r_avm_read && !io_bus.avm_waitrequest;
        w_issue      = (w_start && (io_bus.total_beats != 32'd0))
                     || ((r_state == S_ISSUE) && !r_avm_read
                         && (r_issue_rem != 32'd0) && w_credit);
        w_rd         = io_bus.avm_readdatavalid && (r_state != S_IDLE);
        w_full       = r_fifo_cnt == (FIFO_AW+1)'(FIFO_DEPTH);
        w_wr         = w_rd && !w_full;
        w_pop        = (r_fifo_cnt != '0) && io_bus.dma_data_out_ready;
        w_issue_left = r_issue_rem - 32'(r_avm_bc);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (io_bus.start)
                    w_next = (io_bus.total_beats == 32'd0) ? S_FINISH : S_ISSUE;
            end
            S_ISSUE:  if (w_accept && (w_issue_left == 32'd0)) w_next = S_DRAIN;
            S_DRAIN:  if (r_send_rem == 32'd0) w_next = S_FINISH;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr_q      <= '0;
            r_issue_rem   <= '0;
            r_send_rem    <= '0;
            r_fifo_cnt    <= '0;
            r_outst       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_avm_read    <= 1'b0;
            r_avm_address <= '0;
            r_avm_bc      <= '0;
            r_done        <= 1'b0;
        end else begin
            r_done <= (r_state == S_FINISH);
            if (w_start) begin
                r_addr_q    <= io_bus.base_addr;
                r_issue_rem <= io_bus.total_beats;
                r_send_rem  <= io_bus.total_beats;
            end else begin
                if (w_accept) begin
                    r_addr_q    <= r_addr_q + ADDR_W'(r_avm_bc) * STEP;
                    r_issue_rem <= w_issue_left;
                end
                if (w_pop) r_send_rem <= r_send_rem - 32'd1;
            end
            if (w_issue) begin
                r_avm_read    <= 1'b1;
                r_avm_address <= (r_state == S_IDLE) ? io_bus.base_addr : r_addr_q;
                r_avm_bc      <= w_len;
            end else if (w_accept) begin
                r_avm_read <= 1'b0;
            end
            r_outst <= r_outst
                     + (w_accept ? (FIFO_AW+1)'(r_avm_bc) : '0)
                     - (FIFO_AW+1)'(w_rd);
            r_fifo_cnt <= r_fifo_cnt + (FIFO_AW+1)'(w_wr) - (FIFO_AW+1)'(w_pop);
            if (w_wr)  r_wptr <= r_wptr + FIFO_AW'(1);
            if (w_pop) r_rptr <= r_rptr + FIFO_AW'(1);
            if (w_rd && w_full)
                $error("npu_dma_rd_stream: readdatavalid while FIFO full");
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= io_bus.avm_readdata;
    end

    assign io_bus.busy               = w_busy;
    assign io_bus.done               = r_done;
    assign io_bus.avm_read           = r_avm_read;
    assign io_bus.avm_address        = r_avm_address;
    assign io_bus.avm_burstcount     = r_avm_bc;
    assign io_bus.dma_data_out       = r_mem[r_rptr];
    assign io_bus.dma_data_out_valid = r_fifo_cnt != '0;
endmodule

// File: tb/tb_npu_dma_rd_stream.sv
// Bench for npu_dma_rd_stream: Avalon slave + memory model, stream scoreboard,
// directed jobs covering bursts, backpressure, stalls, empty jobs and reset.
module tb_npu_dma_rd_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    npu_dma_rd_stream_if bus ();
    npu_dma_rd_stream dut (.clk(clk), .rst(rst), .io_bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    int g_wait_pct   = 0;
    int g_ready_mode = 0;
    int g_ready_hold = 0;

    logic [31:0] g_base;
    int          g_beats;
    bit          g_job = 0;
    int          n_out, n_done, exp_rem, n_acc;
    logic [31:0] exp_addr;
    logic [31:0] baddr[$];
    int          blen[$];
    bit          prev_acc, prev_stall;
    logic [31:0] prev_addr;
    logic [3:0]  prev_bc;
    logic [31:0] sq[$];

    function automatic logic [63:0] mw(input logic [31:0] a);
        return {a ^ 32'hC0DE_0000, ~a};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic start_model(input logic [31:0] base, input int beats);
        g_base   = base;
        g_beats  = beats;
        n_out    = 0;
        n_done   = 0;
        n_acc    = 0;
        exp_addr = base;
        exp_rem  = beats;
        baddr.delete();
        blen.delete();
        g_job    = 1;
    endtask

    // Avalon slave: queue accepted bursts, return beats from the memory model.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) sq.delete();
            else if (bus.avm_read && !bus.avm_waitrequest)
                for (int i = 0; i < int'(bus.avm_burstcount); i++)
                    sq.push_back(bus.avm_address + 32'(i * 8));
            #1;
            bus.avm_waitrequest = ($urandom_range(0, 99) < g_wait_pct);
            if (!rst && sq.size() > 0 && $urandom_range(0, 99) >= g_wait_pct) begin
                bus.avm_readdatavalid = 1'b1;
                bus.avm_readdata      = mw(sq.pop_front());
            end else begin
                bus.avm_readdatavalid = 1'b0;
                bus.avm_readdata      = '0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (g_ready_hold > 0) begin
                bus.dma_data_out_ready = 1'b0;
                g_ready_hold--;
            end else if (g_ready_mode == 1) begin
                bus.dma_data_out_ready = 1'($urandom_range(0, 1));
            end else begin
                bus.dma_data_out_ready = 1'b1;
            end
        end
    end

    // Per-cycle scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            prev_acc   = 0;
            prev_stall = 0;
        end else begin
            if (bus.dma_data_out_valid && bus.dma_data_out_ready) begin
                chk("beat_in_job", 64'(g_job && n_out < g_beats), 64'd1);
                chk("beat_data", bus.dma_data_out, mw(g_base + 32'(n_out) * 32'd8));
                n_out++;
            end
            if (prev_acc) chk("no_b2b_read", 64'(bus.avm_read), 64'd0);
            if (prev_stall) begin
                chk("stall_read", 64'(bus.avm_read), 64'd1);
                chk("stall_addr", 64'(bus.avm_address), 64'(prev_addr));
                chk("stall_bc", 64'(bus.avm_burstcount), 64'(prev_bc));
            end
            if (bus.avm_read && !bus.avm_waitrequest) begin
                chk("burst_addr", 64'(bus.avm_address), 64'(exp_addr));
                chk("burst_len", 64'(bus.avm_burstcount),
                    64'((exp_rem > 8) ? 8 : exp_rem));
                baddr.push_back(bus.avm_address);
                blen.push_back(int'(bus.avm_burstcount));
                exp_addr = exp_addr + 32'(bus.avm_burstcount) * 32'd8;
                exp_rem  = exp_rem - int'(bus.avm_burstcount);
                n_acc    = n_acc + int'(bus.avm_burstcount);
            end
            if (g_job) chk("credit", 64'((n_acc - n_out) <= 16), 64'd1);
            if (bus.done) begin
                n_done++;
                chk("busy_low_at_done", 64'(bus.busy), 64'd0);
            end
            prev_acc   = bus.avm_read && !bus.avm_waitrequest;
            prev_stall = bus.avm_read && bus.avm_waitrequest;
            prev_addr  = bus.avm_address;
            prev_bc    = bus.avm_burstcount;
        end
    end

    task automatic run_job(input logic [31:0] base, input int beats,
                           input bit poke, input int budget,
                           output logic rd1, output logic [31:0] ad1,
                           output logic [3:0] bc1, output logic busy1,
                           output logic dn1, output logic dn2);
        int cyc;
        start_model(base, beats);
        @(posedge clk);
        #1;
        bus.start       = 1'b1;
        bus.base_addr   = base;
        bus.total_beats = 32'(beats);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        rd1   = bus.avm_read;
        ad1   = bus.avm_address;
        bc1   = bus.avm_burstcount;
        busy1 = bus.busy;
        dn1   = bus.done;
        @(negedge clk);
        dn2 = bus.done;
        cyc = 0;
        while (n_done == 0 && cyc < budget) begin
            @(posedge clk);
            #1;
            bus.start = poke && (cyc == 2);
            if (poke) begin
                bus.base_addr   = 32'hBAD0_0000;
                bus.total_beats = 32'd3;
            end
            cyc++;
        end
        bus.start = 1'b0;
        chk("job_done_seen", 64'(n_done > 0), 64'd1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("beats_out", 64'(n_out), 64'(beats));
        chk("done_once", 64'(n_done), 64'd1);
        chk("issued_all", 64'(exp_rem), 64'd0);
        chk("idle_after", 64'(bus.busy), 64'd0);
        g_job = 0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_done"}, 64'(bus.done), 64'd0);
        chk({tag, "_read"}, 64'(bus.avm_read), 64'd0);
        chk({tag, "_addr"}, 64'(bus.avm_address), 64'd0);
        chk({tag, "_bc"}, 64'(bus.avm_burstcount), 64'd0);
        chk({tag, "_valid"}, 64'(bus.dma_data_out_valid), 64'd0);
    endtask

    logic        r1, b1, d1, d2;
    logic [31:0] a1;
    logic [3:0]  c1;
    int          cyc;

    initial begin
        bus.start              = 1'b0;
        bus.base_addr          = '0;
        bus.total_beats        = '0;
        bus.avm_waitrequest    = 1'b0;
        bus.avm_readdata       = '0;
        bus.avm_readdatavalid  = 1'b0;
        bus.dma_data_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outs("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // T1: single full burst
        run_job(32'h1000, 8, 0, 200, r1, a1, c1, b1, d1, d2);
        chk("t1_first_read", 64'(r1), 64'd1);
        chk("t1_first_addr", 64'(a1), 64'h1000);
        chk("t1_first_bc", 64'(c1), 64'd8);
        chk("t1_busy", 64'(b1), 64'd1);
        chk("t1_bursts", 64'(baddr.size()), 64'd1);

        // T2: 8,8,4 split, with an ignored start during busy
        run_job(32'h1000, 20, 1, 300, r1, a1, c1, b1, d1, d2);
        chk("t2_bursts", 64'(baddr.size()), 64'd3);
        if (baddr.size() == 3) begin
            chk("t2_a0", 64'(baddr[0]), 64'h1000);
            chk("t2_a1", 64'(baddr[1]), 64'h1040);
            chk("t2_a2", 64'(baddr[2]), 64'h1080);
            chk("t2_l0", 64'(blen[0]), 64'd8);
            chk("t2_l1", 64'(blen[1]), 64'd8);
            chk("t2_l2", 64'(blen[2]), 64'd4);
        end

        // T3: long backpressure
        g_ready_hold = 200;
        run_job(32'h2000, 40, 0, 1000, r1, a1, c1, b1, d1, d2);

        // T4: random waitrequest / readdatavalid gaps / ready
        g_wait_pct   = 50;
        g_ready_mode = 1;
        run_job(32'h2000_0008, 37, 0, 4000, r1, a1, c1, b1, d1, d2);
        run_job(32'h0000_5000, 5, 0, 1000, r1, a1, c1, b1, d1, d2);
        g_wait_pct   = 0;
        g_ready_mode = 0;

        // T5: empty job
        run_job(32'h6000, 0, 0, 20, r1, a1, c1, b1, d1, d2);
        chk("t5_no_read", 64'(r1), 64'd0);
        chk("t5_busy_c1", 64'(b1), 64'd1);
        chk("t5_done_c1", 64'(d1), 64'd0);
        chk("t5_done_c2", 64'(d2), 64'd1);
        chk("t5_bursts", 64'(baddr.size()), 64'd0);

        // T6: reset mid-job, then a clean job
        start_model(32'h3000, 32);
        @(posedge clk);
        #1;
        bus.start       = 1'b1;
        bus.base_addr   = 32'h3000;
        bus.total_beats = 32'd32;
        @(posedge clk);
        #1 bus.start = 1'b0;
        cyc = 0;
        while (n_out < 4 && cyc < 200) begin
            @(posedge clk);
            cyc++;
        end
        chk("t6_progress", 64'(n_out >= 4), 64'd1);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset_outs("t6_rst");
        g_job = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        run_job(32'h4000, 12, 0, 300, r1, a1, c1, b1, d1, d2);
        chk("t6_first_addr", 64'(a1), 64'h4000);
        chk("t6_first_bc", 64'(c1), 64'd8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
